// File: rtl/fifo_pkg.sv
// Shared constants for the bit-addressed FIFO controller.
// Thresholds are typed to the level width so comparisons stay exact.
package fifo_pkg;

  localparam int DEPTH = 512;
  localparam int AW    = 9;

  typedef logic [AW-1:0] adr_t;
  typedef logic [AW:0]   lvl_t;
  typedef logic [3:0]    step_t;

  localparam step_t W_BYTE = 4'd8;
  localparam step_t W_NIB  = 4'd4;
  localparam step_t W_SYM  = 4'd3;

  localparam lvl_t AFULL_LVL = 10'd504;
  localparam lvl_t FULL_LVL  = 10'd508;
  localparam lvl_t EMPTY_LVL = 10'd3;

  function automatic step_t push_w(input logic nib);
    return nib ? W_NIB : W_BYTE;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH bit pointer with clear and variable step.
// Wrap comes for free from the AW-bit adder.
module fifo_ptr
  import fifo_pkg::*;
(
  input  logic  Clk,
  input  logic  Rst,
  input  logic  clr,
  input  logic  en,
  input  step_t step,
  output adr_t  ptr
);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      ptr <= '0;
    else if (clr)
      ptr <= '0;
    else if (en)
      ptr <= ptr + adr_t'(step);
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flow controller for 512-bit bit-addressed FIFO storage.
// 8/4-bit pushes, 3-bit pops, bit-granular fill level and sticky errors.
module fifo_ctrl
  import fifo_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic       wr_req,
  input  logic       wr_nib,
  input  logic [7:0] wr_data,
  input  logic       rd_req,
  input  logic       flush,
  input  logic [2:0] mem_out,
  output logic       wr_ack,
  output logic       rd_valid,
  output logic [2:0] rd_data,
  output logic       mem_wr,
  output logic       mem_bit4,
  output logic [7:0] mem_db,
  output adr_t       mem_in_adr,
  output adr_t       mem_out_adr,
  output logic       mem_out_en,
  output lvl_t       level,
  output logic       empty,
  output logic       afull,
  output logic       full,
  output logic       ovf,
  output logic       udf
);

  adr_t  wr_ptr;
  adr_t  rd_ptr;
  step_t wr_w;
  logic  wr_ok;
  logic  rd_ok;
  logic  wr_ref;
  logic  rd_ref;
  lvl_t  level_nxt;

  assign empty = level < EMPTY_LVL;
  assign afull = level > AFULL_LVL;
  assign full  = level > FULL_LVL;

  assign wr_w   = push_w(wr_nib);
  assign wr_ok  = wr_req & ~flush & (wr_nib ? ~full : ~afull);
  assign rd_ok  = rd_req & ~flush & ~empty;
  assign wr_ref = wr_req & ~flush & ~wr_ok;
  assign rd_ref = rd_req & ~flush & empty;

  // Pop only ever consumes bits already counted, so no underflow here.
  always_comb begin
    level_nxt = level;
    if (wr_ok)
      level_nxt = level_nxt + lvl_t'(wr_w);
    if (rd_ok)
      level_nxt = level_nxt - lvl_t'(W_SYM);
  end

  fifo_ptr u_wr_ptr (
    .Clk  (Clk),
    .Rst  (Rst),
    .clr  (flush),
    .en   (wr_ok),
    .step (wr_w),
    .ptr  (wr_ptr)
  );

  fifo_ptr u_rd_ptr (
    .Clk  (Clk),
    .Rst  (Rst),
    .clr  (flush),
    .en   (rd_ok),
    .step (W_SYM),
    .ptr  (rd_ptr)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      level       <= '0;
      ovf         <= 1'b0;
      udf         <= 1'b0;
      mem_wr      <= 1'b1;
      mem_bit4    <= 1'b0;
      mem_db      <= '0;
      mem_in_adr  <= '0;
      mem_out_adr <= '0;
      mem_out_en  <= 1'b0;
      wr_ack      <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else if (flush) begin
      level      <= '0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
      mem_wr     <= 1'b1;
      mem_out_en <= 1'b0;
      wr_ack     <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      level      <= level_nxt;
      ovf        <= ovf | wr_ref;
      udf        <= udf | rd_ref;
      mem_wr     <= ~wr_ok;
      wr_ack     <= wr_ok;
      mem_out_en <= rd_ok;
      rd_valid   <= mem_out_en;
      if (wr_ok) begin
        mem_db     <= wr_data;
        mem_bit4   <= wr_nib;
        mem_in_adr <= wr_ptr;
      end
      if (rd_ok)
        mem_out_adr <= rd_ptr;
      // Storage read data is valid for the whole enable cycle.
      if (mem_out_en)
        rd_data <= mem_out;
    end
  end

endmodule
